i2c_sub_regfile: RTL and testbench

Parametrised I2C subordinate with an internal byte-wide register file, auto-incrementing register pointer, and write and read bursts. It is the successor to the fixed single-byte subordinates in `I2C_system`. It sits on the shared open-drain SDA/SCL bus, with the tristate and pull-up external to the block. The local host side gets a write-notify strobe and a direct read/write port into the register file.

---
 rtl/i2c_sub_regfile_if.sv | 27 ++
 rtl/i2c_sub_regfile.sv | 217 +++++++++++++++++++++
 tb/tb_i2c_sub_regfile.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_sub_regfile_if.sv
// Bundle of pin, host-port and notify signals for the I2C register-file subordinate.
interface i2c_sub_regfile_if #(
  parameter int unsigned PTR_W = 4
);
  logic             scl_in;
  logic             sda_in;
  logic             sda_oe;
  logic             host_we;
  logic [PTR_W-1:0] host_addr;
  logic [7:0]       host_wdata;
  logic [7:0]       host_rdata;
  logic             wr_strobe;
  logic [PTR_W-1:0] wr_addr;
  logic [7:0]       wr_data;
  logic             busy;
  logic [3:0]       state;

  modport slave (
    input  scl_in, sda_in, host_we, host_addr, host_wdata,
    output sda_oe, host_rdata, wr_strobe, wr_addr, wr_data, busy, state
  );

  modport master (
    output scl_in, sda_in, host_we, host_addr, host_wdata,
    input  sda_oe, host_rdata, wr_strobe, wr_addr, wr_data, busy, state
  );
endinterface

// File: rtl/i2c_sub_regfile.sv
// I2C subordinate fronting a byte register file with auto-incrementing pointer,
// write/read bursts, and a host-side port where I2C commits win index collisions.
module i2c_sub_regfile #(
  parameter logic [6:0]  SUB_ADDR = 7'h01,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned PTR_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  i2c_sub_regfile_if.slave  bus
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_ADDR_ACK  = 4'd2,
    S_PTR       = 4'd3,
    S_PTR_ACK   = 4'd4,
    S_WDATA     = 4'd5,
    S_WDATA_ACK = 4'd6,
    S_RDATA     = 4'd7,
    S_RDATA_ACK = 4'd8,
    S_IGNORE    = 4'd9
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       scl_pipe_q, sda_pipe_q;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             sda_oe_q, sda_oe_d;
  logic             busy_q, busy_d;
  logic             rw_q, rw_d;
  logic             mack_q, mack_d;
  logic             wr_strobe_q, wr_strobe_d;
  logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic [7:0]       regs_q [DEPTH];
  logic [7:0]       regs_d [DEPTH];

  // [0] first sync stage, [1] synchronised level, [2] one-cycle history
  logic scl_s, scl_h, sda_s, sda_h;
  logic scl_rise, scl_fall, start_det, stop_det, addr_match;
  logic [7:0] rx_byte, rd_byte;

  assign scl_s      = scl_pipe_q[1];
  assign scl_h      = scl_pipe_q[2];
  assign sda_s      = sda_pipe_q[1];
  assign sda_h      = sda_pipe_q[2];
  assign scl_rise   = scl_s & ~scl_h;
  assign scl_fall   = ~scl_s & scl_h;
  assign start_det  = scl_s & scl_h & sda_h & ~sda_s;
  assign stop_det   = scl_s & scl_h & ~sda_h & sda_s;
  assign rx_byte    = {shift_q[6:0], sda_s};
  assign rd_byte    = regs_q[ptr_q];
  assign addr_match = (rx_byte[7:1] == SUB_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start_det) begin
      state_d = S_ADDR;
    end else if (stop_det) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_ADDR:      if (scl_rise && bit_cnt_q == 4'd7) state_d = addr_match ? S_ADDR_ACK : S_IGNORE;
        S_ADDR_ACK:  if (scl_fall && bit_cnt_q == 4'd9) state_d = rw_q ? S_RDATA : S_PTR;
        S_PTR:       if (scl_rise && bit_cnt_q == 4'd7) state_d = S_PTR_ACK;
        S_PTR_ACK:   if (scl_fall && bit_cnt_q == 4'd9) state_d = S_WDATA;
        S_WDATA:     if (scl_rise && bit_cnt_q == 4'd7) state_d = S_WDATA_ACK;
        S_WDATA_ACK: if (scl_fall && bit_cnt_q == 4'd9) state_d = S_WDATA;
        S_RDATA:     if (scl_fall && bit_cnt_q == 4'd8) state_d = S_RDATA_ACK;
        S_RDATA_ACK: if (scl_fall && bit_cnt_q == 4'd9) state_d = mack_q ? S_IGNORE : S_RDATA;
        default:     state_d = state_q;
      endcase
    end
  end

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    rw_d        = rw_q;
    mack_d      = mack_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    regs_d      = regs_q;
    // host write first so a same-index I2C commit below overrides it
    if (bus.host_we) regs_d[bus.host_addr] = bus.host_wdata;
    if (start_det) begin
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_PTR, S_WDATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              if (state_q == S_ADDR) begin
                busy_d = addr_match;
                rw_d   = rx_byte[0];
              end else if (state_q == S_PTR) begin
                ptr_d = rx_byte[PTR_W-1:0];
              end else begin
                regs_d[ptr_q] = rx_byte;
                wr_strobe_d   = 1'b1;
                wr_addr_d     = ptr_q;
                wr_data_d     = rx_byte;
                ptr_d         = ptr_q + PTR_W'(1);
              end
            end
          end
        end
        S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b1;
              bit_cnt_d = 4'd9;
            end else begin
              bit_cnt_d = '0;
              sda_oe_d  = 1'b0;
              if (state_q == S_ADDR_ACK && rw_q) begin
                shift_d  = {rd_byte[6:0], 1'b0};
                sda_oe_d = ~rd_byte[7];
                ptr_d    = ptr_q + PTR_W'(1);
              end
            end
          end
        end
        S_RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd9;
            end else begin
              sda_oe_d = ~shift_q[7];
              shift_d  = {shift_q[6:0], 1'b0};
            end
          end
        end
        S_RDATA_ACK: begin
          if (scl_rise) begin
            mack_d = sda_s;
          end else if (scl_fall) begin
            bit_cnt_d = '0;
            if (mack_q) begin
              sda_oe_d = 1'b0;
              busy_d   = 1'b0;
            end else begin
              shift_d  = {rd_byte[6:0], 1'b0};
              sda_oe_d = ~rd_byte[7];
              ptr_d    = ptr_q + PTR_W'(1);
            end
          end
        end
        S_IGNORE: sda_oe_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_pipe_q  <= '1;
      sda_pipe_q  <= '1;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      ptr_q       <= '0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      rw_q        <= 1'b0;
      mack_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      scl_pipe_q  <= {scl_pipe_q[1:0], bus.scl_in};
      sda_pipe_q  <= {sda_pipe_q[1:0], bus.sda_in};
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      rw_q        <= rw_d;
      mack_q      <= mack_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      regs_q      <= regs_d;
    end
  end

  assign bus.sda_oe     = sda_oe_q;
  assign bus.wr_strobe  = wr_strobe_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.busy       = busy_q;
  assign bus.state      = state_q;
  assign bus.host_rdata = regs_q[bus.host_addr];

endmodule

// File: tb/tb_i2c_sub_regfile.sv
// Bench for i2c_sub_regfile: bit-level I2C master, array reference model and
// a strobe scoreboard monitor.
module tb_i2c_sub_regfile;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned PTR_W = 4;
  localparam int unsigned Q     = 6;

  typedef struct {
    int a;
    int d;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   oe_viol = 0;
  bit   oe_seen = 1'b0;
  logic prev_oe = 1'b0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [7:0] wq[$];
  logic [7:0] model_regs [DEPTH];
  int   model_ptr = 0;

  always #5 clk = ~clk;

  i2c_sub_regfile_if #(.PTR_W(PTR_W)) bus ();

  assign bus.scl_in = m_scl;
  assign bus.sda_in = m_sda & ~bus.sda_oe;

  i2c_sub_regfile #(.SUB_ADDR(7'h01), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // scoreboard monitor: every wr_strobe pops one expected commit
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.wr_strobe) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL strobe_unexpected actual=%0h/%0h expected=none", bus.wr_addr, bus.wr_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("strobe_addr", int'(bus.wr_addr), mon_e.a);
          chk("strobe_data", int'(bus.wr_data), mon_e.d);
        end
      end
      if (bus.sda_oe) oe_seen = 1'b1;
      if (bus.sda_oe !== prev_oe && m_scl) oe_viol++;
    end
    prev_oe = bus.sda_oe;
  end

  task automatic i2c_start();
    m_sda = 1'b1; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    m_sda = 1'b1; wait_clk(Q);
  endtask

  // optional host write placed in the exact cycle the DUT sees this SCL rise
  task automatic send_bit(input logic b, input bit coll, input int hidx, input int hdat);
    m_sda = b; wait_clk(Q);
    m_scl = 1'b1;
    if (coll) begin
      wait_clk(2);
      bus.host_we = 1'b1; bus.host_addr = PTR_W'(hidx); bus.host_wdata = 8'(hdat);
      wait_clk(1);
      bus.host_we = 1'b0;
      wait_clk(2 * Q - 3);
    end else begin
      wait_clk(2 * Q);
    end
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic recv_bit(output logic b);
    m_sda = 1'b1; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    b = bus.sda_in; wait_clk(Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic send_byte(input logic [7:0] v, input bit coll, input int hidx, input int hdat,
                           output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(v[i], coll && (i == 0), hidx, hdat);
    recv_bit(ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] v);
    logic b;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      recv_bit(b);
      v = {v[6:0], b};
    end
    send_bit(nack, 1'b0, 0, 0);
  endtask

  // write transaction of pointer + wq[] bytes; hidx >= 0 collides a host write with the first commit
  task automatic do_write(input logic [6:0] addr, input logic [7:0] p, input int hidx, input int hdat);
    logic ack;
    bit match;
    match = (addr == 7'h01);
    oe_seen = 1'b0;
    i2c_start();
    send_byte({addr, 1'b0}, 1'b0, 0, 0, ack);
    chk("addr_ack", int'(ack), match ? 0 : 1);
    if (match) chk("busy_addressed", int'(bus.busy), 1);
    send_byte(p, 1'b0, 0, 0, ack);
    chk("ptr_ack", int'(ack), match ? 0 : 1);
    if (match) model_ptr = int'(p) % DEPTH;
    for (int k = 0; k < wq.size(); k++) begin
      if (match) begin
        if (k == 0 && hidx >= 0 && hidx != model_ptr) model_regs[hidx] = 8'(hdat);
        exp_q.push_back('{model_ptr, int'(wq[k])});
        model_regs[model_ptr] = wq[k];
        model_ptr = (model_ptr + 1) % DEPTH;
      end else if (k == 0 && hidx >= 0) begin
        model_regs[hidx] = 8'(hdat);
      end
      send_byte(wq[k], (k == 0) && (hidx >= 0), hidx, hdat, ack);
      chk("data_ack", int'(ack), match ? 0 : 1);
    end
    i2c_stop();
    wait_clk(4);
    chk("busy_after_stop", int'(bus.busy), 0);
    if (!match) chk("oe_quiet_mismatch", int'(oe_seen), 0);
  endtask

  task automatic do_read(input logic [7:0] p, input int n);
    logic ack;
    logic [7:0] v;
    i2c_start();
    send_byte(8'h02, 1'b0, 0, 0, ack);
    chk("rd_waddr_ack", int'(ack), 0);
    send_byte(p, 1'b0, 0, 0, ack);
    chk("rd_ptr_ack", int'(ack), 0);
    model_ptr = int'(p) % DEPTH;
    i2c_start();
    send_byte(8'h03, 1'b0, 0, 0, ack);
    chk("rd_raddr_ack", int'(ack), 0);
    for (int k = 0; k < n; k++) begin
      recv_byte(k == n - 1, v);
      chk("rd_byte", int'(v), int'(model_regs[model_ptr]));
      model_ptr = (model_ptr + 1) % DEPTH;
    end
    wait_clk(2);
    chk("rd_oe_released", int'(bus.sda_oe), 0);
    chk("rd_busy_after_nack", int'(bus.busy), 0);
    i2c_stop();
    wait_clk(4);
  endtask

  task automatic host_write(input int idx, input int val);
    bus.host_we = 1'b1; bus.host_addr = PTR_W'(idx); bus.host_wdata = 8'(val);
    wait_clk(1);
    bus.host_we = 1'b0;
    model_regs[idx] = 8'(val);
  endtask

  task automatic check_regs();
    for (int i = 0; i < DEPTH; i++) begin
      bus.host_addr = PTR_W'(i);
      #1;
      chk($sformatf("reg%0d", i), int'(bus.host_rdata), int'(model_regs[i]));
    end
    wait_clk(1);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] addr_byte;
    logic [6:0] ra;
    int kind, n;
    bit got;
    bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
    for (int i = 0; i < DEPTH; i++) model_regs[i] = '0;
    wait_clk(4);
    chk("rst_sda_oe", int'(bus.sda_oe), 0);
    chk("rst_strobe", int'(bus.wr_strobe), 0);
    chk("rst_wr_addr", int'(bus.wr_addr), 0);
    chk("rst_wr_data", int'(bus.wr_data), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_state", int'(bus.state), 0);
    rst = 1'b0;
    wait_clk(5);
    check_regs();

    wq.delete(); wq.push_back(8'hAA);
    do_write(7'h01, 8'h03, -1, 0);
    wq.delete(); wq.push_back(8'h11); wq.push_back(8'h22); wq.push_back(8'h33);
    do_write(7'h01, 8'h0E, -1, 0);
    do_read(8'h0E, 3);
    wq.delete();
    do_write(7'h03, 8'h55, -1, 0);
    wq.delete(); wq.push_back(8'h99);
    do_write(7'h01, 8'h05, 5, 8'h77);
    do_write(7'h01, 8'h05, 6, 8'h77);
    check_regs();

    // reset asserted while the subordinate is pulling SDA for an ACK
    i2c_start();
    addr_byte = 8'h02;
    for (int i = 7; i >= 0; i--) send_bit(addr_byte[i], 1'b0, 0, 0);
    m_sda = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (bus.sda_oe) got = 1'b1;
      else wait_clk(1);
    end
    chk("oe_in_ack", int'(got), 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_oe", int'(bus.sda_oe), 0);
    chk("rst_mid_state", int'(bus.state), 0);
    chk("rst_mid_busy", int'(bus.busy), 0);
    for (int i = 0; i < DEPTH; i++) model_regs[i] = '0;
    exp_q.delete();
    m_scl = 1'b1; m_sda = 1'b1;
    wait_clk(3);
    check_regs();
    rst = 1'b0;
    wait_clk(5);
    wq.delete(); wq.push_back(8'h5A); wq.push_back(8'hC3);
    do_write(7'h01, 8'h07, -1, 0);
    check_regs();

    for (int it = 0; it < 16; it++) begin
      kind = int'($urandom_range(0, 3));
      n = int'($urandom_range(1, 4));
      case (kind)
        0: begin
          wq.delete();
          for (int k = 0; k < n; k++) wq.push_back(8'($urandom_range(0, 255)));
          do_write(7'h01, 8'($urandom_range(0, 255)), -1, 0);
        end
        1: do_read(8'($urandom_range(0, 255)), n);
        2: begin
          do ra = 7'($urandom_range(0, 127)); while (ra == 7'h01);
          wq.delete();
          for (int k = 0; k < n; k++) wq.push_back(8'($urandom_range(0, 255)));
          do_write(ra, 8'($urandom_range(0, 255)), -1, 0);
        end
        default: host_write(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 255)));
      endcase
    end
    check_regs();
    chk("strobes_outstanding", exp_q.size(), 0);
    chk("oe_changed_scl_high", oe_viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
